onehot_rr_arbiter: RTL

- Round-robin arbiter sitting directly upstream of the one-hot key-to-code mux stage.
- Accepts a multi-hot request vector, with one bit per key lane, and emits one registered one-hot grant plus its binary index under a valid/ready handshake.
- Downstream uses the binary index as the mux key and the one-hot grant as the lane code.
- Rotating priority guarantees starvation-free service of all NR_KEY lanes.

---
 rtl/gpc_arb_pkg.sv | 17 +
 rtl/onehot_rr_arbiter_if.sv | 31 +++
 rtl/onehot_rr_pick.sv | 40 ++++
 rtl/onehot_rr_arbiter.sv | 101 ++++++++++
 4 files changed

// File: rtl/gpc_arb_pkg.sv
// Shared types and helpers for the grant arbiters feeding the key-to-code mux stage.
package gpc_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  // Index width for n lanes; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage : gpc_arb_pkg

// File: rtl/onehot_rr_arbiter_if.sv
// Request/grant bundle between the lane requesters, the arbiter and the mux consumer.
interface onehot_rr_arbiter_if
  import gpc_arb_pkg::*;
#(
  parameter int unsigned NR_KEY = 2
);
  localparam int unsigned IDX_W = clog2_min1(NR_KEY);

  logic [NR_KEY-1:0] req;
  logic              gnt_valid;
  logic              gnt_ready;
  logic [NR_KEY-1:0] gnt;
  logic [IDX_W-1:0]  gnt_idx;

  modport master (
    input  req,
    input  gnt_ready,
    output gnt_valid,
    output gnt,
    output gnt_idx
  );

  modport slave (
    output req,
    output gnt_ready,
    input  gnt_valid,
    input  gnt,
    input  gnt_idx
  );

endinterface : onehot_rr_arbiter_if

// File: rtl/onehot_rr_pick.sv
// Combinational rotating-priority pick: first set req bit at or after ptr, wrapping.
module onehot_rr_pick
  import gpc_arb_pkg::*;
#(
  parameter int unsigned NR_KEY = 2
) (
  input  logic [NR_KEY-1:0]                  req,
  input  logic [clog2_min1(NR_KEY)-1:0]      ptr,
  output logic                               any,
  output logic [NR_KEY-1:0]                  win_onehot,
  output logic [clog2_min1(NR_KEY)-1:0]      win_idx
);

  localparam int unsigned IDX_W = clog2_min1(NR_KEY);
  localparam int unsigned SUM_W = IDX_W + 1;

  logic [NR_KEY-1:0] rot;
  logic [SUM_W-1:0]  off;
  logic [SUM_W-1:0]  sum;
  logic              found;

  // Rotate so ptr lands at bit 0, priority-encode, then map the offset back to a lane.
  always_comb begin
    rot   = NR_KEY'({req, req} >> ptr);
    any   = |req;
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (!found && rot[i]) begin
        off   = SUM_W'(i);
        found = 1'b1;
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= SUM_W'(NR_KEY)) sum = sum - SUM_W'(NR_KEY);
    win_idx    = IDX_W'(sum);
    win_onehot = any ? (NR_KEY'(1) << win_idx) : '0;
  end

endmodule : onehot_rr_pick

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter issuing a registered one-hot grant + index under valid/ready.
// Define ONEHOT_RR_ARBITER_B2B_EN to re-arbitrate on the handshake cycle (1 grant/cycle).
module onehot_rr_arbiter
  import gpc_arb_pkg::*;
#(
  parameter int unsigned NR_KEY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  onehot_rr_arbiter_if.master bus
);

  localparam int unsigned IDX_W = clog2_min1(NR_KEY);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d, pick_ptr;
  logic [NR_KEY-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              hs;
  logic              any;
  logic [NR_KEY-1:0] win_onehot;
  logic [IDX_W-1:0]  win_idx;

  // Pointer advances past the accepted lane, wrapping at the last lane.
  always_comb begin
    hs    = (state_q == ARB_GRANT) && bus.gnt_ready;
    ptr_d = ptr_q;
    if (hs) ptr_d = (gnt_idx_q == IDX_W'(NR_KEY - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
`ifdef ONEHOT_RR_ARBITER_B2B_EN
    pick_ptr = ptr_d;
`else
    pick_ptr = ptr_q;
`endif
  end

  onehot_rr_pick #(
    .NR_KEY(NR_KEY)
  ) u_pick (
    .req       (bus.req),
    .ptr       (pick_ptr),
    .any       (any),
    .win_onehot(win_onehot),
    .win_idx   (win_idx)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    case (state_q)
      ARB_IDLE: begin
        if (any) begin
          state_d     = ARB_GRANT;
          gnt_d       = win_onehot;
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
        end
      end
      ARB_GRANT: begin
        // Grant is sticky until accepted, regardless of req changes.
        if (hs) begin
          state_d     = ARB_IDLE;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
`ifdef ONEHOT_RR_ARBITER_B2B_EN
          if (any) begin
            state_d     = ARB_GRANT;
            gnt_d       = win_onehot;
            gnt_idx_d   = win_idx;
            gnt_valid_d = 1'b1;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;

endmodule : onehot_rr_arbiter
